shared_wide_adder_sched: RTL

- Round-robin scheduler that shares one combinational 16-bit carry-lookahead adder slice between NUM_REQ requesters.
- Each request is a WORDS×16-bit add or subtract, executed least-significant word first, one word per cycle, with the carry chained through a register.
- Sits between requester blocks and a single adder instance, which is connected to the add_* ports.

---
 rtl/shared_wide_adder_sched.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/shared_wide_adder_sched.sv
// Round-robin scheduler that time-shares one external 16-bit adder slice among
// NUM_REQ requesters. It runs WORDS-word add/sub operations LS word first, one word per cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// req_ready never depends on anything but req_valid, state, pointer and rst.
// rsp_valid stays high and rsp_* stay stable until rsp_ready is seen.
module shared_wide_adder_sched #(
    parameter  int NUM_REQ = 2,
    parameter  int WORDS   = 4,
    localparam int W       = 16 * WORDS,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_cin,
    input  logic [NUM_REQ-1:0]   req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf,
    output logic                 busy,
    output logic [1:0]           state_dbg,
    output logic [15:0]          add_a,
    output logic [15:0]          add_b,
    output logic                 add_cin,
    input  logic [15:0]          add_sum,
    input  logic                 add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_lat;
    logic [W-1:0]       b_lat;
    logic               cin_eff;
    logic               carry_reg;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               found;
    int                 cand;
    logic               accept;
    logic               last_word;

    // Search from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_id    = ID_W'(cand);
            end
        end
    end

    assign accept    = (state == IDLE) && found;
    assign last_word = (idx == IDX_W'(WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_word) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state == IDLE && !rst) req_ready = grant;
        if (state == RUN) begin
            add_a   = a_lat[idx*16 +: 16];
            add_b   = b_lat[idx*16 +: 16];
            add_cin = (idx == '0) ? cin_eff : carry_reg;
        end
        busy      = (state != IDLE);
        rsp_valid = (state == DONE);
        state_dbg = state;
    end

    // Subtraction is A + ~B + 1, so B is inverted at accept and cin forced to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            idx       <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            cin_eff   <= 1'b0;
            carry_reg <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else if (accept) begin
            a_lat   <= req_a[grant_id*W +: W];
            b_lat   <= req_b[grant_id*W +: W] ^ {W{req_sub[grant_id]}};
            cin_eff <= req_sub[grant_id] | req_cin[grant_id];
            rsp_id  <= grant_id;
            ptr     <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            idx     <= '0;
        end else if (state == RUN) begin
            rsp_sum[idx*16 +: 16] <= add_sum;
            carry_reg             <= add_cout;
            idx                   <= idx + IDX_W'(1);
            if (last_word) begin
                rsp_cout <= add_cout;
                rsp_ovf  <= (a_lat[W-1] == b_lat[W-1]) && (add_sum[15] != a_lat[W-1]);
            end
        end
    end

endmodule
